// File: rtl/adc_udp_packetizer_pkg.sv
// Shared types and constants for the ADC-to-UDP packetizer.
`timescale 1ns/1ps
package eth_pkg;

    // Header is seq[15:8], seq[7:0], flags, reserved
    localparam int HDR_BYTES = 4;

    typedef enum logic [1:0] {
        GAP,
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    // Bytes in one burst: header plus two bytes per sample
    function automatic int burst_len(input int samples_per_pkt);
        return HDR_BYTES + 2 * samples_per_pkt;
    endfunction

endpackage

// File: rtl/adc_udp_packetizer_if.sv
// Byte-stream bus from the packetizer into the UDP transmit generator.
`timescale 1ns/1ps
interface adc_udp_packetizer_if;

    logic       udp_tx_valid;
    logic [7:0] udp_tx_data;
    logic       udp_tx_busy;

    modport master (
        output udp_tx_valid,
        output udp_tx_data,
        input  udp_tx_busy
    );

    modport slave (
        input  udp_tx_valid,
        input  udp_tx_data,
        output udp_tx_busy
    );

endinterface

// File: rtl/adc_udp_packetizer_sample_fifo.sv
// First-word-fall-through sample FIFO, 16 bits wide, power-of-two depth.
// full/empty come from the registered level, so a same-cycle read never
// makes room for a write.
`timescale 1ns/1ps
module sample_fifo #(
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   rd_en,
    output logic [15:0]            rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_wr;
    logic          w_rd;

    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == '0);
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

    // Sample storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/adc_udp_packetizer.sv
// Frames buffered ADC samples into contiguous byte bursts for the UDP
// transmit path: 4-byte header (sequence, flags, reserved) followed by
// SAMPLES_PER_PKT big-endian 16-bit samples.
`timescale 1ns/1ps
module adc_udp_packetizer
    import eth_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int SAMPLES_PER_PKT = 256,
    parameter int FIFO_DEPTH      = 1024,
    parameter int GAP_CYCLES      = 16
) (
    input  logic                        clk_125m,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic [SAMPLE_W-1:0]         sample_data,
    adc_udp_packetizer_if.master        tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 pkt_seq
);

    localparam int BURST_LEN = burst_len(SAMPLES_PER_PKT);
    localparam int IDX_W     = $clog2(BURST_LEN);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [IDX_W-1:0] r_byte_idx;   // index of the byte loaded on the next edge
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic [15:0]      r_pkt_seq;
    logic [15:0]      r_drop_cnt;
    logic             r_ovf;        // sticky: a sample was dropped since last header
    logic             r_hdr_ovf;    // flag captured for the header in flight

    logic [15:0]      w_sample_ext;
    logic [15:0]      w_fifo_rd_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_drop;
    logic             w_pop;
    logic             w_start;

    assign w_sample_ext = 16'(sample_data);
    assign w_drop       = sample_valid && w_fifo_full;
    // Odd byte indices in the payload are the low bytes; each one consumes a sample
    assign w_pop        = (r_state == PAYLOAD) && r_byte_idx[0] && !w_fifo_empty;
    assign w_start      = (r_state == IDLE) && enable && !tx.udp_tx_busy &&
                          (fifo_level >= LVL_W'(SAMPLES_PER_PKT));

    assign tx.udp_tx_valid = r_tx_valid;
    assign tx.udp_tx_data  = r_tx_data;
    assign drop_count      = r_drop_cnt;
    assign pkt_seq         = r_pkt_seq;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_125m),
        .rst     (rst),
        .wr_en   (sample_valid),
        .wr_data (w_sample_ext),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

    // Burst sequencer with registered byte output, drop accounting and overflow flag
    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            r_state    <= GAP;
            r_gap_cnt  <= '0;
            r_byte_idx <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_pkt_seq  <= 16'h0000;
            r_drop_cnt <= 16'h0000;
            r_ovf      <= 1'b0;
            r_hdr_ovf  <= 1'b0;
        end else begin
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                GAP: begin
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= 8'h00;
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end

                IDLE: begin
                    if (w_start) begin
                        r_state    <= HDR;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= r_pkt_seq[15:8];
                        r_byte_idx <= IDX_W'(1);
                    end
                end

                HDR: begin
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                    if (r_byte_idx == IDX_W'(1)) begin
                        // First header cycle: hand the flag to this packet; a drop
                        // landing right now belongs to the next one
                        r_tx_data <= r_pkt_seq[7:0];
                        r_hdr_ovf <= r_ovf;
                        r_ovf     <= w_drop;
                    end else if (r_byte_idx == IDX_W'(2)) begin
                        r_tx_data <= {7'd0, r_hdr_ovf};
                    end else begin
                        r_tx_data <= 8'h00;
                        r_state   <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    r_tx_data <= r_byte_idx[0] ? w_fifo_rd_data[7:0] : w_fifo_rd_data[15:8];
                    if (r_byte_idx == IDX_W'(BURST_LEN - 1)) begin
                        r_byte_idx <= '0;
                        r_pkt_seq  <= r_pkt_seq + 16'd1;
                        r_state    <= GAP;
                    end else begin
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                    end
                end

                default: r_state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_udp_packetizer.sv
// Bench for adc_udp_packetizer: directed scenarios plus randomized traffic,
// with a queue-based reference model checked on every clock.
`timescale 1ns/1ps
module tb_adc_udp_packetizer;

    localparam int SW    = 12;
    localparam int SPP   = 4;
    localparam int DEPTH = 16;
    localparam int G     = 3;
    localparam int BL    = 4 + 2 * SPP;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b0;
    logic                     sample_valid = 1'b0;
    logic [SW-1:0]            sample_data = '0;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [15:0]              drop_count;
    logic [15:0]              pkt_seq;

    adc_udp_packetizer_if bus();

    adc_udp_packetizer #(
        .SAMPLE_W        (SW),
        .SAMPLES_PER_PKT (SPP),
        .FIFO_DEPTH      (DEPTH),
        .GAP_CYCLES      (G)
    ) dut (
        .clk_125m     (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .tx           (bus),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .pkt_seq      (pkt_seq)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q[$];          // samples accepted and not yet sent
    logic [7:0]  expb[$];       // bytes of the burst in flight
    logic [7:0]  blog[$];       // every byte of completed bursts
    int          bst[$], ben[$], bofs[$];
    int          nbursts = 0;
    bit          in_burst = 1'b0;
    int          pos = 0, cur_st = 0, cur_ofs = 0;
    int          idle_cnt = 0;
    bit          p_allow = 1'b0, p_req = 1'b0;
    logic [15:0] m_drop = 16'h0, m_seq = 16'h0;
    bit          m_ovf = 1'b0;

    always @(negedge clk) begin : mon
        logic [15:0] s;
        bit          cond;
        if (rst) begin
            chk("rst_valid", 32'(bus.udp_tx_valid), 0);
            chk("rst_data", 32'(bus.udp_tx_data), 0);
            chk("rst_level", 32'(fifo_level), 0);
            chk("rst_drop", 32'(drop_count), 0);
            chk("rst_seq", 32'(pkt_seq), 0);
            q.delete();
            m_drop = 0; m_ovf = 0; m_seq = 0;
            in_burst = 0; pos = 0; idle_cnt = 0;
            p_allow = 0; p_req = 0;
        end else begin
            if (!in_burst) begin
                if (bus.udp_tx_valid) begin
                    chk("start_allowed", 32'(p_allow), 1);
                    expb.delete();
                    expb.push_back(m_seq[15:8]);
                    expb.push_back(m_seq[7:0]);
                    expb.push_back({7'd0, m_ovf});
                    expb.push_back(8'h00);
                    for (int i = 0; i < SPP; i++) begin
                        s = (i < q.size()) ? q[i] : 16'h0;
                        expb.push_back(s[15:8]);
                        expb.push_back(s[7:0]);
                    end
                    m_ovf    = 0;
                    in_burst = 1;
                    pos      = 0;
                    cur_st   = cyc;
                    cur_ofs  = blog.size();
                end else begin
                    chk("idle_data", 32'(bus.udp_tx_data), 0);
                    chk("missed_start", 32'(p_req), 0);
                end
            end
            if (in_burst) begin
                chk("burst_valid", 32'(bus.udp_tx_valid), 1);
                chk("burst_byte", 32'(bus.udp_tx_data), 32'(expb[pos]));
                blog.push_back(bus.udp_tx_data);
                if (pos >= 4 && pos[0] && q.size() > 0) void'(q.pop_front());
                pos++;
                if (pos == BL || !bus.udp_tx_valid) begin
                    in_burst = 0;
                    bst.push_back(cur_st);
                    ben.push_back(cyc);
                    bofs.push_back(cur_ofs);
                    nbursts++;
                    if (pos == BL) m_seq = m_seq + 16'd1;
                end
            end
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("drop_count", 32'(drop_count), 32'(m_drop));
            chk("pkt_seq", 32'(pkt_seq), 32'(m_seq));

            idle_cnt = bus.udp_tx_valid ? 0 : idle_cnt + 1;
            cond     = enable && !bus.udp_tx_busy && (q.size() >= SPP);
            p_allow  = cond && (idle_cnt >= G);
            p_req    = cond && (idle_cnt >= G + 1);

            if (sample_valid) begin
                if (q.size() >= DEPTH) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    m_ovf = 1;
                end else begin
                    q.push_back(16'(sample_data));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put(input logic [SW-1:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int budget);
        for (int k = 0; k < budget && nbursts < n; k++) tick();
        chk("burst_timeout", 32'(nbursts >= n), 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int k = 0; k < budget && !bus.udp_tx_valid; k++) tick();
        chk("valid_timeout", 32'(bus.udp_tx_valid), 1);
    endtask

    logic [7:0] lit1 [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23,
                              8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};

    initial begin
        int base;
        int rel;
        bus.udp_tx_busy = 1'b0;

        // T1: single packet, known bytes
        do_reset();
        chk("t1_reset_valid", 32'(bus.udp_tx_valid), 0);
        chk("t1_reset_level", 32'(fifo_level), 0);
        enable = 1'b1;
        base = nbursts;
        put(12'h123); put(12'h456); put(12'h789); put(12'hABC);
        wait_bursts(base + 1, 100);
        if (nbursts > base) begin
            for (int i = 0; i < BL; i++) chk("t1_byte", 32'(blog[bofs[base] + i]), 32'(lit1[i]));
            chk("t1_len", 32'(ben[base] - bst[base] + 1), 12);
        end
        tick(); tick();
        chk("t1_seq", 32'(pkt_seq), 1);
        chk("t1_level", 32'(fifo_level), 0);

        // T2: busy holds off the burst
        do_reset();
        enable = 1'b1;
        bus.udp_tx_busy = 1'b1;
        base = nbursts;
        for (int i = 0; i < 8; i++) put(SW'($urandom));
        repeat (42) tick();
        chk("t2_no_burst_busy", 32'(nbursts), 32'(base));
        chk("t2_no_valid_busy", 32'(bus.udp_tx_valid), 0);
        rel = cyc;
        bus.udp_tx_busy = 1'b0;
        wait_bursts(base + 2, 200);
        if (nbursts > base + 1) begin
            chk("t2_start_after_release", 32'(bst[base]), 32'(rel + 1));
            chk("t2_seq_hi", 32'(blog[bofs[base + 1]]), 32'h00);
            chk("t2_seq_lo", 32'(blog[bofs[base + 1] + 1]), 32'h01);
            chk("t2_gap", 32'(bst[base + 1] - ben[base] - 1 >= G), 1);
        end

        // T3: overflow flag reporting
        do_reset();
        enable = 1'b0;
        base = nbursts;
        for (int i = 0; i < DEPTH + 5; i++) put(SW'(i));
        chk("t3_drop", 32'(drop_count), 5);
        chk("t3_level_full", 32'(fifo_level), DEPTH);
        enable = 1'b1;
        wait_bursts(base + 4, 300);
        if (nbursts > base + 1) begin
            chk("t3_flags_first", 32'(blog[bofs[base] + 2]), 32'h01);
            chk("t3_flags_next", 32'(blog[bofs[base + 1] + 2]), 32'h00);
        end
        chk("t3_drop_hold", 32'(drop_count), 5);

        // T4: sequence wrap
        do_reset();
        enable = 1'b0;
        base = nbursts;
        for (int i = 0; i < 8; i++) put(SW'($urandom));
        force dut.r_pkt_seq = 16'hFFFF;
        m_seq = 16'hFFFF;
        tick();
        release dut.r_pkt_seq;
        tick();
        enable = 1'b1;
        wait_bursts(base + 2, 200);
        if (nbursts > base + 1) begin
            chk("t4_hdr_ff_hi", 32'(blog[bofs[base]]), 32'hFF);
            chk("t4_hdr_ff_lo", 32'(blog[bofs[base] + 1]), 32'hFF);
            chk("t4_hdr_00_hi", 32'(blog[bofs[base + 1]]), 32'h00);
            chk("t4_hdr_00_lo", 32'(blog[bofs[base + 1] + 1]), 32'h00);
        end
        chk("t4_seq_after", 32'(pkt_seq), 1);

        // T5: reset during the 6th byte
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) put(SW'($urandom));
        wait_valid(100);
        repeat (5) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(bus.udp_tx_valid), 0);
        chk("t5_async_data", 32'(bus.udp_tx_data), 0);
        tick();
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_seq", 32'(pkt_seq), 0);
        rst = 1'b0;
        rel = cyc;
        base = nbursts;
        for (int i = 0; i < 4; i++) put(SW'($urandom));
        wait_bursts(base + 1, 100);
        if (nbursts > base) chk("t5_restart_cycle", 32'(bst[base]), 32'(rel + 5));

        // T6: enable dropped mid-payload
        do_reset();
        enable = 1'b1;
        base = nbursts;
        for (int i = 0; i < 4; i++) put(SW'($urandom));
        wait_valid(100);
        repeat (6) tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) put(SW'($urandom));
        repeat (20) tick();
        chk("t6_one_burst", 32'(nbursts), 32'(base + 1));
        if (nbursts > base) chk("t6_full_len", 32'(ben[base] - bst[base] + 1), 12);
        chk("t6_level", 32'(fifo_level), 4);
        enable = 1'b1;
        wait_bursts(base + 2, 100);

        // Randomized traffic: light then heavy load
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable          = ($urandom_range(7) != 0);
            bus.udp_tx_busy = ($urandom_range(3) == 0);
            sample_valid    = ($urandom_range(5) < ((i < 1500) ? 1 : 3));
            sample_data     = SW'($urandom);
            tick();
        end
        sample_valid    = 1'b0;
        enable          = 1'b1;
        bus.udp_tx_busy = 1'b0;
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
